// File: rtl/sliced_add_sequencer.sv
// Multi-cycle wide adder: one 4-bit slice per clock through fourbit_rp, LSB first.
// Optional subtract mode when SLICE_ADD_SUB_EN is defined (adds the `sub` input).
`timescale 1ns/1ps

module fourbit_rp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end
endmodule

module sliced_add_sequencer #(
  parameter int SLICES = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [4*SLICES-1:0] A,
  input  logic [4*SLICES-1:0] B,
  input  logic                cin,
`ifdef SLICE_ADD_SUB_EN
  input  logic                sub,
`endif
  output logic                ready,
  output logic                done,
  output logic [4*SLICES-1:0] S,
  output logic                cout
);
  localparam int W  = 4 * SLICES;
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic            last_slice;
  logic [3:0]      slice_b;
  logic [3:0]      slice_s;
  logic            slice_co;
  logic            sub_q;

  // Operand copies shift right each RUN cycle, so the active slice is always bits [3:0].
  assign last_slice = (cnt_q == CW'(SLICES - 1));
  assign slice_b    = b_q[3:0] ^ {4{sub_q}};

  fourbit_rp u_slice (
    .a  (a_q[3:0]),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      S       <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      done    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            cnt_q <= '0;
            S     <= '0;
`ifdef SLICE_ADD_SUB_EN
            sub_q   <= sub;
            carry_q <= sub | cin & ~sub;
`else
            sub_q   <= 1'b0;
            carry_q <= cin;
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= slice_co;
          for (int k = 0; k < SLICES; k++) begin
            if (cnt_q == CW'(k)) S[4*k +: 4] <= slice_s;
          end
          if (last_slice) begin
            cout  <= slice_co;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sliced_add_sequencer.sv
// Directed self-checking bench for sliced_add_sequencer (SLICES=4, W=16).
`timescale 1ns/1ps

module tb_sliced_add_sequencer;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        ready, done, cout;
  logic [15:0] S;

  int checks = 0;
  int errors = 0;

  sliced_add_sequencer #(.SLICES(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .cin     (cin),
`ifdef SLICE_ADD_SUB_EN
    .sub     (sub),
`endif
    .ready   (ready),
    .done    (done),
    .S       (S),
    .cout    (cout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles the inputs after acceptance, optionally pokes
  // start during RUN, and checks latency, result and the single done pulse.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s_en, input logic inject,
                        input logic [15:0] exp_s, input logic exp_c);
    int n;
    @(negedge Clk);
    start = 1'b1; A = a; B = b; cin = c; sub = s_en;
    @(posedge Clk); #1;
    check({tag, "_busy"}, ready, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      start = inject && (n == 1);
      A     = start ? 16'hAAAA : ~a;
      B     = 16'h5A5A;
      cin   = ~c;
      sub   = ~s_en;
      @(posedge Clk); #1;
      n++;
      if (done) break;
    end
    @(negedge Clk);
    start = 1'b0;
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, S, exp_s);
    check({tag, "_cout"}, cout, exp_c);
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_back"}, ready, 1);
    check({tag, "_sum_held"}, S, exp_s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    #12;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_sum", S, 0);
    check("rst_cout", cout, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Abort mid-RUN: two slices in, S holds the low byte and cout still shows the last add.
    @(negedge Clk);
    start = 1'b1; A = 16'h1234; B = 16'h4321; cin = 1'b0; sub = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #1;
    check("t5_mid_sum", S, 16'h0055);
    check("t5_mid_cout", cout, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t5_rst_ready", ready, 1);
    check("t5_rst_done", done, 0);
    check("t5_rst_sum", S, 0);
    check("t5_rst_cout", cout, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op("t5", 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);

    run_op("t3", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      A = 16'hFFFF; B = 16'hFFFF; cin = 1'b1;
      @(posedge Clk); #1;
      check("t3_hold_sum", S, 16'h0001);
      check("t3_hold_cout", cout, 0);
      check("t3_hold_ready", ready, 1);
    end

    run_op("t4", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (done) extra++;
    end
    check("t4_no_queued_op", extra, 0);

`ifdef SLICE_ADD_SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    run_op("t6b", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
